// File: rtl/led_pattern_driver.sv
// Multi-channel LED driver: OFF/ON/BLINK/PWM per channel from one free-running counter.
// New MODE/DUTY settings are held pending and only become active at a PWM period boundary.
module led_pattern_driver #(
  parameter int NUM_CH     = 3,
  parameter int CNT_W      = 26,
  parameter int PWM_W      = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      LOAD,
  input  logic [2*NUM_CH-1:0]       MODE,
  input  logic [PWM_W*NUM_CH-1:0]   DUTY,
  output logic                      BUSY,
  output logic [NUM_CH-1:0]         LED
);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PWM   = 2'b11;
  localparam logic       POL_S      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [CNT_W-1:0]        cnt_r;
  logic [2*NUM_CH-1:0]     active_mode_r;
  logic [PWM_W*NUM_CH-1:0] active_duty_r;
  logic [2*NUM_CH-1:0]     pend_mode_r;
  logic [PWM_W*NUM_CH-1:0] pend_duty_r;
  logic                    pend_valid_r;
  logic [NUM_CH-1:0]       led_r;
  logic [NUM_CH-1:0]       lit_s;
  logic [PWM_W-1:0]        pwm_cnt_s;
  logic                    boundary_s;

  assign pwm_cnt_s  = cnt_r[PWM_W-1:0];
  assign boundary_s = &pwm_cnt_s;
  assign BUSY       = pend_valid_r;
  assign LED        = led_r;

  // Counter, config double buffer and registered pad drive
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r         <= {CNT_W{1'b0}};
      active_mode_r <= {(2*NUM_CH){1'b0}};
      active_duty_r <= {(PWM_W*NUM_CH){1'b0}};
      pend_mode_r   <= {(2*NUM_CH){1'b0}};
      pend_duty_r   <= {(PWM_W*NUM_CH){1'b0}};
      pend_valid_r  <= 1'b0;
      led_r         <= {NUM_CH{POL_S}};
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      led_r <= lit_s ^ {NUM_CH{POL_S}};
      if (LOAD) begin
        pend_mode_r <= MODE;
        pend_duty_r <= DUTY;
      end
      if (boundary_s) begin
        // A LOAD landing on the boundary bypasses the buffer so it is never lost
        if (LOAD) begin
          active_mode_r <= MODE;
          active_duty_r <= DUTY;
        end else if (pend_valid_r) begin
          active_mode_r <= pend_mode_r;
          active_duty_r <= pend_duty_r;
        end
        pend_valid_r <= 1'b0;
      end else if (LOAD) begin
        pend_valid_r <= 1'b1;
      end
    end
  end

  // Per-channel lit state from the current counter and active config
  always_comb begin
    lit_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      case (active_mode_r[2*i +: 2])
        MODE_OFF:   lit_s[i] = 1'b0;
        MODE_ON:    lit_s[i] = 1'b1;
        MODE_BLINK: lit_s[i] = cnt_r[CNT_W-1];
        MODE_PWM:   lit_s[i] = (pwm_cnt_s < active_duty_r[PWM_W*i +: PWM_W]);
        default:    lit_s[i] = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver with NUM_CH=3, CNT_W=6, PWM_W=3, ACTIVE_LOW=1.
module tb_led_pattern_driver;

  logic       CLK;
  logic       RST_N;
  logic       LOAD;
  logic [5:0] MODE;
  logic [8:0] DUTY;
  logic       BUSY;
  logic [2:0] LED;

  int checks;
  int failures;
  int tcnt;

  led_pattern_driver #(
    .NUM_CH(3), .CNT_W(6), .PWM_W(3), .ACTIVE_LOW(1)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .MODE(MODE),
    .DUTY(DUTY), .BUSY(BUSY), .LED(LED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // tcnt tracks the value the DUT counter holds after each edge
  task automatic tick();
    @(posedge CLK);
    #1;
    tcnt = (tcnt + 1) % 64;
  endtask

  task automatic wait_pwm(input int p);
    for (int k = 0; k < 8; k++) begin
      if (tcnt % 8 == p) break;
      tick();
    end
  endtask

  task automatic load_commit(input logic [5:0] m, input logic [8:0] d);
    wait_pwm(2);
    MODE = m; DUTY = d; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    wait_pwm(0);
    chk("commit_busy_low", BUSY, 1'b0);
    tick();
  endtask

  task automatic pwm_period(input int d);
    int lows;
    int prevp;
    logic eb;
    lows = 0;
    for (int k = 0; k < 8; k++) begin
      prevp = (tcnt + 7) % 8;
      eb = (prevp < d) ? 1'b0 : 1'b1;
      chk("pwm_led", LED, {eb, eb, eb});
      if (LED[0] == 1'b0) lows++;
      tick();
    end
    chk("pwm_low_count", lows, d);
  endtask

  initial begin
    int lows;
    int prev;
    logic b5;
    checks = 0; failures = 0; tcnt = 0;
    RST_N = 1'b0; LOAD = 1'b0; MODE = 6'd0; DUTY = 9'd0;

    // 1. reset and idle
    #23;
    chk("rst_led", LED, 3'b111);
    chk("rst_busy", BUSY, 1'b0);
    RST_N = 1'b1;
    tcnt = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      chk("idle_led", LED, 3'b111);
    end
    chk("idle_busy", BUSY, 1'b0);

    // 2. static modes: ch2 BLINK, ch1 ON, ch0 OFF, loaded at pwm_cnt=2
    wait_pwm(2);
    MODE = 6'b10_01_00; DUTY = 9'd0; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t2_busy_hi", BUSY, 1'b1);
      tick();
    end
    chk("t2_busy_lo", BUSY, 1'b0);
    chk("t2_led_old_cfg", LED, 3'b111);
    for (int k = 0; k < 64; k++) begin
      tick();
      prev = (tcnt + 63) % 64;
      b5 = (prev >= 32) ? 1'b1 : 1'b0;
      chk("t2_led", LED, {~b5, 1'b0, 1'b1});
    end

    // 3. PWM duty sweep
    load_commit(6'b11_11_11, {3'd0, 3'd0, 3'd0});
    pwm_period(0);
    load_commit(6'b11_11_11, {3'd3, 3'd3, 3'd3});
    pwm_period(3);
    load_commit(6'b11_11_11, {3'd7, 3'd7, 3'd7});
    pwm_period(7);

    // 4. glitch-free duty change 6 -> 1 loaded mid-period
    load_commit(6'b11_11_11, {3'd6, 3'd6, 3'd6});
    lows = 0;
    for (int k = 0; k < 8; k++) begin
      if (LED[0] == 1'b0) lows++;
      if (tcnt % 8 == 3) begin
        MODE = 6'b11_11_11; DUTY = {3'd6, 3'd6, 3'd1}; LOAD = 1'b1;
      end else begin
        LOAD = 1'b0;
      end
      tick();
    end
    LOAD = 1'b0;
    chk("t4_old_period_lows", lows, 6);
    chk("t4_first_new_low", LED[0], 1'b0);
    lows = 0;
    for (int k = 0; k < 8; k++) begin
      if (LED[0] == 1'b0) lows++;
      tick();
    end
    chk("t4_new_period_lows", lows, 1);

    // 5a. LOAD in the boundary cycle: ch0 ON, others OFF
    wait_pwm(7);
    MODE = 6'b00_00_01; DUTY = 9'd0; LOAD = 1'b1;
    chk("t5a_busy_pre", BUSY, 1'b0);
    tick();
    LOAD = 1'b0;
    chk("t5a_busy_after", BUSY, 1'b0);
    chk("t5a_led_old", LED, 3'b111);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t5a_led_new", LED, 3'b110);
      chk("t5a_busy", BUSY, 1'b0);
    end

    // 5b. back-to-back LOADs, only the second commits
    wait_pwm(1);
    MODE = 6'b00_01_00; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    chk("t5b_busy1", BUSY, 1'b1);
    wait_pwm(4);
    MODE = 6'b01_00_00; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    chk("t5b_busy2", BUSY, 1'b1);
    chk("t5b_led_hold", LED, 3'b110);
    wait_pwm(0);
    chk("t5b_busy_lo", BUSY, 1'b0);
    tick();
    chk("t5b_led_second", LED, 3'b011);
    tick();
    chk("t5b_led_second2", LED, 3'b011);

    // 6. reset while a config is pending
    wait_pwm(2);
    MODE = 6'b01_01_01; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    chk("t6_busy_pend", BUSY, 1'b1);
    wait_pwm(4);
    RST_N = 1'b0;
    #1;
    chk("t6_rst_led", LED, 3'b111);
    chk("t6_rst_busy", BUSY, 1'b0);
    #2;
    RST_N = 1'b1;
    tcnt = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("t6_led_dark", LED, 3'b111);
      chk("t6_busy", BUSY, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
